// File: rtl/fp_arb_pkg.sv
// Shared constants and helpers for the floating-point adder arbiter.
// FP_ARB_SLICE picks lane idx (width w) out of a flat multi-port bus.
`ifndef FP_ARB_PKG_SV
`define FP_ARB_PKG_SV
`define FP_ARB_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package fp_arb_pkg;

  localparam logic [31:0] FP_ONE = 32'h3F80_0000;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < value) r++;
    return r;
  endfunction

endpackage

`endif

// File: rtl/fp_tag_fifo.sv
// In-order tag FIFO recording which requester owns each operation in flight.
// Push and pop may occur in the same cycle; depth must be a power of two.
module fp_tag_fifo
  import fp_arb_pkg::*;
#(
  parameter int C_WIDTH = 2,
  parameter int C_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [C_WIDTH-1:0]           push_data,
  input  logic                         pop,
  output logic [C_WIDTH-1:0]           pop_data,
  output logic [clog2(C_DEPTH):0]      count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = clog2(C_DEPTH);

  logic [C_WIDTH-1:0] mem_q [C_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W:0]     count_q;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == (PTR_W+1)'(C_DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one pipelined FP adder among C_NUM_REQ requesters.
// Define FP_ADD_ARB_STATS_EN to add per-port 32-bit accept counters (stat_issue_cnt).
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_NUM_REQ    = 4,
  parameter int C_TAG_DEPTH  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [C_NUM_REQ-1:0]              req_valid,
  input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_a,
  input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_b,
  output logic [C_NUM_REQ-1:0]              req_ready,
  output logic [C_NUM_REQ-1:0]              rsp_valid,
  output logic [C_DATA_WIDTH-1:0]           rsp_data,
  output logic [C_DATA_WIDTH-1:0]           add_a,
  output logic [C_DATA_WIDTH-1:0]           add_b,
  output logic                              add_valid,
  input  logic [C_DATA_WIDTH-1:0]           add_result,
  input  logic                              add_rdy,
  output logic                              tag_err
`ifdef FP_ADD_ARB_STATS_EN
  ,
  output logic [C_NUM_REQ*32-1:0]           stat_issue_cnt
`endif
);

  localparam int TAG_W = clog2(C_NUM_REQ);
  localparam int CNT_W = clog2(C_TAG_DEPTH) + 1;

  logic [TAG_W-1:0]        rr_q, rr_d;
  logic [TAG_W-1:0]        grant_idx_s, cand_s, pop_tag_s;
  logic                    grant_any_s, accept_s, pop_s;
  logic                    fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]        fifo_count_s;
  logic [C_NUM_REQ-1:0]    ready_s;
  logic [C_DATA_WIDTH-1:0] mux_a_s, mux_b_s;
  logic [C_NUM_REQ-1:0]    rsp_valid_q;
  logic [C_DATA_WIDTH-1:0] rsp_data_q, add_a_q, add_b_q;
  logic                    add_valid_q, tag_err_q;

  // Scan downward from the farthest candidate so the one nearest the pointer wins.
  always_comb begin
    int idx;
    idx         = 0;
    cand_s      = '0;
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    for (int k = C_NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= C_NUM_REQ) idx = idx - C_NUM_REQ;
      cand_s = TAG_W'(idx);
      if (req_valid[cand_s]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // A full FIFO can still accept when a result pops in the same cycle.
  always_comb begin
    ready_s = '0;
    if (grant_any_s && !reset && (!fifo_full_s || add_rdy)) begin
      ready_s[grant_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  always_comb begin
    mux_a_s = '0;
    mux_b_s = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (grant_idx_s == TAG_W'(i)) begin
        mux_a_s = `FP_ARB_SLICE(req_a, i, C_DATA_WIDTH);
        mux_b_s = `FP_ARB_SLICE(req_b, i, C_DATA_WIDTH);
      end else begin
        mux_a_s = mux_a_s;
      end
    end
  end

  assign accept_s  = |ready_s;
  assign pop_s     = add_rdy && !fifo_empty_s;
  assign rr_d      = (grant_idx_s == TAG_W'(C_NUM_REQ - 1)) ? '0 : grant_idx_s + TAG_W'(1);
  assign req_ready = ready_s;

  fp_tag_fifo #(
    .C_WIDTH (TAG_W),
    .C_DEPTH (C_TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept_s),
    .push_data (grant_idx_s),
    .pop       (pop_s),
    .pop_data  (pop_tag_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Issue registers, result routing and the sticky orphan-result flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q        <= '0;
      add_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      tag_err_q   <= 1'b0;
    end else begin
      add_valid_q <= accept_s;
      if (accept_s) begin
        add_a_q <= mux_a_s;
        add_b_q <= mux_b_s;
        rr_q    <= rr_d;
      end
      rsp_valid_q <= '0;
      if (pop_s) begin
        rsp_valid_q[pop_tag_s] <= 1'b1;
        rsp_data_q             <= add_result;
      end
      if (add_rdy && fifo_empty_s) tag_err_q <= 1'b1;
    end
  end

  assign add_valid = add_valid_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign tag_err   = tag_err_q;

`ifdef FP_ADD_ARB_STATS_EN
  logic [31:0] stat_q [C_NUM_REQ];

  // Per-port accept counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < C_NUM_REQ; i++) stat_q[i] <= 32'd0;
    end else if (accept_s) begin
      stat_q[grant_idx_s] <= stat_q[grant_idx_s] + 32'd1;
    end
  end

  for (genvar g = 0; g < C_NUM_REQ; g++) begin : g_stat
    assign stat_issue_cnt[g*32 +: 32] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed self-checking bench for fp_add_arbiter; the bench plays the adder core.
module tb_fp_add_arbiter;
  import fp_arb_pkg::*;

  localparam int W = 32;
  localparam int N = 4;
  localparam int D = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [W-1:0]   rsp_data, add_a, add_b, add_result;
  logic           add_valid, add_rdy, tag_err;
`ifdef FP_ADD_ARB_STATS_EN
  logic [N*32-1:0] stat_issue_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];

  always #5 clk = ~clk;

  fp_add_arbiter #(.C_DATA_WIDTH(W), .C_NUM_REQ(N), .C_TAG_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
    .add_result(add_result), .add_rdy(add_rdy), .tag_err(tag_err)
`ifdef FP_ADD_ARB_STATS_EN
    , .stat_issue_cnt(stat_issue_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    add_result = '0; add_rdy = 1'b0;
    for (int i = 0; i < N; i++) begin
      opa[i] = 32'h1000_0000 + 32'(i);
      opb[i] = 32'h2000_0000 + 32'(i);
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
    end
    tick; tick;
    check_eq("rst_add_valid", 64'(add_valid), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_tag_err", 64'(tag_err), 64'd0);
    check_eq("rst_add_a", 64'(add_a), 64'd0);
    req_valid = 4'b1111;
    #1;
    check_eq("rst_ready_gated", 64'(req_ready), 64'd0);
    reset = 1'b0;
    #1;

    // T2: all ports contending, round-robin from port 0
    for (int c = 0; c < 8; c++) begin
      check_eq("t2_grant", 64'(req_ready), 64'(4'b0001 << (c % 4)));
      tick;
      check_eq("t2_add_valid", 64'(add_valid), 64'd1);
      check_eq("t2_add_a", 64'(add_a), 64'(opa[c % 4]));
      check_eq("t2_add_b", 64'(add_b), 64'(opb[c % 4]));
    end
    req_valid = '0;
    for (int c = 0; c < 8; c++) begin
      add_rdy = 1'b1;
      add_result = 32'hA000_0000 + 32'(c);
      tick;
      check_eq("t2_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << (c % 4)));
      check_eq("t2_rsp_data", 64'(rsp_data), 64'(32'hA000_0000 + 32'(c)));
    end
    add_rdy = 1'b0;
    tick;
    check_eq("t2_rsp_idle", 64'(rsp_valid), 64'd0);
    check_eq("t2_add_idle", 64'(add_valid), 64'd0);

    // T1: single op on port 0 (pointer back at 0 after 8 grants)
    req_a[0 +: W] = FP_ONE;
    req_b[0 +: W] = 32'h4000_0000;
    req_valid = 4'b0001;
    #1;
    check_eq("t1_ready", 64'(req_ready), 64'd1);
    tick;
    req_valid = '0;
    check_eq("t1_add_valid", 64'(add_valid), 64'd1);
    check_eq("t1_add_a", 64'(add_a), 64'h3F80_0000);
    check_eq("t1_add_b", 64'(add_b), 64'h4000_0000);
    tick;
    check_eq("t1_add_valid_drop", 64'(add_valid), 64'd0);
    check_eq("t1_add_a_hold", 64'(add_a), 64'h3F80_0000);
    tick; tick;
    check_eq("t1_no_early_rsp", 64'(rsp_valid), 64'd0);
    add_rdy = 1'b1;
    add_result = 32'h4040_0000;
    tick;
    add_rdy = 1'b0;
    check_eq("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    check_eq("t1_rsp_data", 64'(rsp_data), 64'h4040_0000);
    tick;
    check_eq("t1_rsp_pulse", 64'(rsp_valid), 64'd0);

    // T3: FIFO fill with adder withholding results
    req_valid = 4'b0010;
    #1;
    for (int c = 0; c < D; c++) begin
      check_eq("t3_fill_ready", 64'(req_ready), 64'b0010);
      tick;
    end
    check_eq("t3_full_ready", 64'(req_ready), 64'd0);
    tick;
    check_eq("t3_full_no_issue", 64'(add_valid), 64'd0);
    add_rdy = 1'b1;
    add_result = 32'h4100_0000;
    #1;
    check_eq("t3_pop_ready", 64'(req_ready), 64'b0010);
    tick;
    add_rdy = 1'b0;
    check_eq("t3_pop_issue", 64'(add_valid), 64'd1);
    check_eq("t3_pop_rsp", 64'(rsp_valid), 64'b0010);
    #1;
    check_eq("t3_still_full", 64'(req_ready), 64'd0);
    req_valid = '0;
    add_rdy = 1'b1;
    for (int c = 0; c < D; c++) begin
      tick;
      check_eq("t3_drain_rsp", 64'(rsp_valid), 64'b0010);
    end
    add_rdy = 1'b0;
    tick;
    check_eq("t3_drained", 64'(rsp_valid), 64'd0);
    check_eq("t3_no_err", 64'(tag_err), 64'd0);

    // T4: spurious result with empty FIFO
    add_rdy = 1'b1;
    add_result = 32'hDEAD_BEEF;
    tick;
    add_rdy = 1'b0;
    check_eq("t4_err_set", 64'(tag_err), 64'd1);
    check_eq("t4_no_rsp", 64'(rsp_valid), 64'd0);
    tick; tick;
    check_eq("t4_err_sticky", 64'(tag_err), 64'd1);

    // T5: reset with 5 ops in flight (pointer at 2 after T3)
    req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 5; c++) begin
      check_eq("t5_grant", 64'(req_ready), 64'(4'b0001 << ((c + 2) % 4)));
      tick;
    end
    req_valid = '0;
    check_eq("t5_pre_valid", 64'(add_valid), 64'd1);
    reset = 1'b1;
    tick;
    check_eq("t5_add_valid", 64'(add_valid), 64'd0);
    check_eq("t5_add_a", 64'(add_a), 64'd0);
    check_eq("t5_add_b", 64'(add_b), 64'd0);
    check_eq("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("t5_rsp_data", 64'(rsp_data), 64'd0);
    check_eq("t5_tag_err", 64'(tag_err), 64'd0);
    reset = 1'b0;
    req_valid = 4'b1111;
    #1;
    check_eq("t5_grant_port0", 64'(req_ready), 64'd1);
    req_valid = '0;
    add_rdy = 1'b1;
    tick;
    add_rdy = 1'b0;
    check_eq("t5_stale_err", 64'(tag_err), 64'd1);
    check_eq("t5_stale_no_rsp", 64'(rsp_valid), 64'd0);

`ifdef FP_ADD_ARB_STATS_EN
    // T6: per-port accept counters
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_eq("t6_cleared", 64'(stat_issue_cnt), 64'd0);
    req_valid = 4'b0100;
    repeat (10) tick;
    req_valid = 4'b0001;
    repeat (3) tick;
    req_valid = '0;
    check_eq("t6_port0", 64'(stat_issue_cnt[0*32 +: 32]), 64'd3);
    check_eq("t6_port1", 64'(stat_issue_cnt[1*32 +: 32]), 64'd0);
    check_eq("t6_port2", 64'(stat_issue_cnt[2*32 +: 32]), 64'd10);
    check_eq("t6_port3", 64'(stat_issue_cnt[3*32 +: 32]), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
